// File: rtl/e_multi_stream_io.sv
// Stream front/back end for a wide limb multiplier: loads A then B limbs, waits SETTLE
// cycles, captures the product and streams it out LS limb first. Option: E_MULTI_STREAM_CHECKSUM_EN.
module e_multi_stream_io #(
  parameter int WORDS  = 32,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [15:0]           s_data,
  output logic [16*WORDS-1:0]   mul_a,
  output logic [16*WORDS-1:0]   mul_b,
  input  logic [32*WORDS-1:0]   mul_p,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int PL  = 2 * WORDS;
`ifdef E_MULTI_STREAM_CHECKSUM_EN
  localparam int OL  = PL + 1;
`else
  localparam int OL  = PL;
`endif
  localparam int CW  = $clog2(WORDS);
  localparam int PIW = $clog2(PL);
  localparam int OCW = $clog2(OL);
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [SW-1:0]          r_wcnt;
  logic [OCW-1:0]         r_ocnt;
  logic [WORDS-1:0][15:0] r_a;
  logic [WORDS-1:0][15:0] r_b;
  logic [PL-1:0][15:0]    r_prod;
  logic                   r_m_valid;

  logic w_in_xfer, w_out_xfer, w_last_in, w_last_out, w_settled;

  assign s_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_in_xfer  = s_valid & s_ready;
  assign w_out_xfer = r_m_valid & m_ready;
  assign w_last_in  = (r_cnt == CW'(WORDS - 1));
  assign w_last_out = (r_ocnt == OCW'(OL - 1));
  assign w_settled  = (r_wcnt == SW'(SETTLE - 1));

  assign mul_a   = r_a;
  assign mul_b   = r_b;
  assign m_valid = r_m_valid;
  assign m_last  = w_last_out;
  assign busy    = !((r_state == S_LOAD_A) && (r_cnt == '0));

`ifdef E_MULTI_STREAM_CHECKSUM_EN
  logic [15:0] w_chk;
  always_comb begin
    w_chk = '0;
    for (int i = 0; i < PL; i++) w_chk = w_chk ^ r_prod[i];
  end
  // The extra slot after the last product limb carries the XOR of the captured limbs.
  assign m_data = (r_ocnt == OCW'(PL)) ? w_chk : r_prod[r_ocnt[PIW-1:0]];
`else
  assign m_data = r_prod[r_ocnt];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOAD_A;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_ocnt    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_prod    <= '0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_A: if (w_in_xfer) begin
          r_a[r_cnt] <= s_data;
          if (w_last_in) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_B;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD_B: if (w_in_xfer) begin
          r_b[r_cnt] <= s_data;
          if (w_last_in) begin
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 1'b1;
          // Multiplier output is only trusted once the operand buses have settled.
          if (w_settled) begin
            r_prod    <= mul_p;
            r_m_valid <= 1'b1;
            r_state   <= S_UNLOAD;
          end
        end
        default: if (w_out_xfer) begin
          if (w_last_out) begin
            r_m_valid <= 1'b0;
            r_ocnt    <= '0;
            r_state   <= S_LOAD_A;
          end else begin
            r_ocnt <= r_ocnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_multi_stream_io.sv
// Bench for e_multi_stream_io: directed table vectors, reset/backpressure/back-to-back
// sequences, and random packets checked against an arithmetic product model.
module tb_e_multi_stream_io;
  localparam int WORDS  = 2;
  localparam int SETTLE = 2;
`ifdef E_MULTI_STREAM_CHECKSUM_EN
  localparam int NOUT = 2 * WORDS + 1;
`else
  localparam int NOUT = 2 * WORDS;
`endif

  logic                clk, rst_n, s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [15:0]         s_data, m_data;
  logic [16*WORDS-1:0] mul_a, mul_b;
  logic [32*WORDS-1:0] mul_p;

  assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

  e_multi_stream_io #(.WORDS(WORDS), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [31:0] a, b;
    logic [15:0] e0, e1, e2, e3;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void push_exp(input logic [15:0] l0, l1, l2, l3);
    exp_q.delete();
    exp_q.push_back(l0); exp_q.push_back(l1); exp_q.push_back(l2); exp_q.push_back(l3);
`ifdef E_MULTI_STREAM_CHECKSUM_EN
    exp_q.push_back(l0 ^ l1 ^ l2 ^ l3);
`endif
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    push_exp(p[15:0], p[31:16], p[47:32], p[63:48]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_limb(input logic [15:0] d, output int acc);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
    tick();
    acc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b, input int gap_max,
                          output int t_first, output int t_last);
    logic [15:0] l[4];
    int g, t;
    l[0] = a[15:0]; l[1] = a[31:16]; l[2] = b[15:0]; l[3] = b[31:16];
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) tick();
      send_limb(l[i], t);
      if (i == 0) t_first = t;
    end
    t_last = t;
    chk("mul_a", {32'd0, mul_a}, {32'd0, a});
    chk("mul_b", {32'd0, mul_b}, {32'd0, b});
  endtask

  task automatic recv_pkt(input int smin, input int smax, input bit junk, input bit hold,
                          input int t_last, output int t_end);
    int n, st;
    n = 0;
    if (junk) s_valid = 1'b1;
    while (!m_valid && n < 50) begin
      if (junk) begin chk("junk_ready_wait", {63'd0, s_ready}, 64'd0); s_data = 16'($urandom); end
      tick();
      n++;
    end
    chk("valid_latency", 64'(cyc - t_last), 64'(SETTLE));
    for (int i = 0; i < NOUT; i++) begin
      st = $urandom_range(smin, smax);
      if (st > 0) m_ready = 1'b0;
      for (int k = 0; k < st; k++) begin
        chk("hold_valid", {63'd0, m_valid}, 64'd1);
        chk("hold_data", {48'd0, m_data}, {48'd0, exp_q[i]});
        chk("hold_last", {63'd0, m_last}, {63'd0, (i == NOUT - 1)});
        if (junk) begin chk("junk_ready", {63'd0, s_ready}, 64'd0); s_data = 16'($urandom); end
        tick();
      end
      m_ready = 1'b1;
      chk("out_valid", {63'd0, m_valid}, 64'd1);
      chk("out_data", {48'd0, m_data}, {48'd0, exp_q[i]});
      chk("out_last", {63'd0, m_last}, {63'd0, (i == NOUT - 1)});
      tick();
      if (!hold) m_ready = 1'b0;
    end
    t_end = cyc;
    s_valid = 1'b0;
    chk("end_valid", {63'd0, m_valid}, 64'd0);
    chk("end_busy", {63'd0, busy}, 64'd0);
    chk("end_ready", {63'd0, s_ready}, 64'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_last", {63'd0, m_last}, 64'd0);
    chk("rst_m_data", {48'd0, m_data}, 64'd0);
    chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
    chk("rst_mul_b", {32'd0, mul_b}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int tf, tl, te, t;
    logic [31:0] ra, rb;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0001, 16'h0000, 16'hFFFE, 16'hFFFF};
    tbl[1] = '{32'h0000_0003, 32'h0000_0005, 16'h000F, 16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{32'h0001_0000, 32'h0001_0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    tbl[3] = '{32'h1234_5678, 32'h0000_0002, 16'hACF0, 16'h2468, 16'h0000, 16'h0000};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) tick();
    chk_reset_vals();
    rst_n = 1'b1;
    tick();

    // directed table: product limbs and checksum from hand-computed values
    for (int v = 0; v < 4; v++) begin
      send_pkt(tbl[v].a, tbl[v].b, 0, tf, tl);
      push_exp(tbl[v].e0, tbl[v].e1, tbl[v].e2, tbl[v].e3);
      recv_pkt((v == 1) ? 5 : 0, (v == 1) ? 5 : 0, 1'b0, 1'b0, tl, te);
    end

    // junk on the input while waiting/unloading must not leak into the next packet
    send_pkt(32'h0007_0009, 32'h0003_0002, 1, tf, tl);
    model(32'h0007_0009, 32'h0003_0002);
    recv_pkt(0, 2, 1'b1, 1'b0, tl, te);
    send_pkt(32'hBEEF_1234, 32'h0101_0404, 0, tf, tl);
    model(32'hBEEF_1234, 32'h0101_0404);
    recv_pkt(0, 1, 1'b0, 1'b0, tl, te);

    // reset in the middle of a load discards the partial packet
    send_limb(16'h1111, t);
    chk("busy_mid_load", {63'd0, busy}, 64'd1);
    send_limb(16'h2222, t);
    send_limb(16'h3333, t);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    tick();
    chk_reset_vals();
    rst_n = 1'b1;
    tick();
    send_pkt(32'h0004_0006, 32'h0000_0010, 0, tf, tl);
    model(32'h0004_0006, 32'h0000_0010);
    recv_pkt(0, 0, 1'b0, 1'b0, tl, te);

    // back-to-back packets with m_ready held high
    m_ready = 1'b1;
    send_pkt(32'hCAFE_0001, 32'h0002_8000, 0, tf, tl);
    model(32'hCAFE_0001, 32'h0002_8000);
    recv_pkt(0, 0, 1'b0, 1'b1, tl, te);
    send_pkt(32'h0000_FFFF, 32'h0000_FFFF, 0, tf, tl);
    chk("b2b_first_accept", 64'(tf - te), 64'd1);
    model(32'h0000_FFFF, 32'h0000_FFFF);
    recv_pkt(0, 0, 1'b0, 1'b1, tl, te);
    m_ready = 1'b0;

    // random packets against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      ra = $urandom;
      rb = $urandom;
      send_pkt(ra, rb, 3, tf, tl);
      model(ra, rb);
      recv_pkt(0, 3, 1'($urandom_range(0, 1)), 1'b0, tl, te);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
